// File: rtl/pa_ifu_btb_upd_ctrl_if.sv
// ---------------------------------------------------------------------------
// pa_ifu_btb_upd_ctrl_if
//
// Purpose:
//   Bundles every signal the BTB update controller exchanges with its
//   neighbours: the IU update request handshake, the CP0 invalidate
//   handshake, and the write-side bus into the BTB entry array.
//
// Signal summary:
//   iu_ifu_btb_upd_vld/del/tag/tgt  IU -> ctrl  update request payload
//   ifu_iu_btb_upd_rdy              ctrl -> IU  request accepted when vld & rdy
//   cp0_ifu_btb_inv                 CP0 -> ctrl invalidate-all pulse
//   ifu_cp0_btb_inv_done            ctrl -> CP0 one-cycle done pulse
//   btb_entry_wr_hit                array -> ctrl per-entry write-tag hit
//   btb_wr_acc_tag                  ctrl -> array tag for the write-hit compare
//   btb_upd_tag/btb_upd_tgt         ctrl -> array write data
//   btb_entry_upd/updg              ctrl -> array one-hot update strobe/gate
//   btb_entry_clr/clrg              ctrl -> array clear strobe/gate
//
// Modports:
//   master - the controller itself (drives the array write side)
//   slave  - the surrounding IU/CP0/array environment
// ---------------------------------------------------------------------------
interface pa_ifu_btb_upd_ctrl_if #(
    parameter int ENTRY_NUM      = 16,
    parameter int BTB_ADDR_WIDTH = 16
);
    logic                      iu_ifu_btb_upd_vld;
    logic                      iu_ifu_btb_upd_del;
    logic [BTB_ADDR_WIDTH-1:0] iu_ifu_btb_upd_tag;
    logic [BTB_ADDR_WIDTH-1:0] iu_ifu_btb_upd_tgt;
    logic                      ifu_iu_btb_upd_rdy;

    logic                      cp0_ifu_btb_inv;
    logic                      ifu_cp0_btb_inv_done;

    logic [ENTRY_NUM-1:0]      btb_entry_wr_hit;
    logic [BTB_ADDR_WIDTH-1:0] btb_wr_acc_tag;
    logic [BTB_ADDR_WIDTH-1:0] btb_upd_tag;
    logic [BTB_ADDR_WIDTH-1:0] btb_upd_tgt;
    logic [ENTRY_NUM-1:0]      btb_entry_upd;
    logic [ENTRY_NUM-1:0]      btb_entry_updg;
    logic [ENTRY_NUM-1:0]      btb_entry_clr;
    logic [ENTRY_NUM-1:0]      btb_entry_clrg;

    modport master (
        input  iu_ifu_btb_upd_vld,
        input  iu_ifu_btb_upd_del,
        input  iu_ifu_btb_upd_tag,
        input  iu_ifu_btb_upd_tgt,
        output ifu_iu_btb_upd_rdy,
        input  cp0_ifu_btb_inv,
        output ifu_cp0_btb_inv_done,
        input  btb_entry_wr_hit,
        output btb_wr_acc_tag,
        output btb_upd_tag,
        output btb_upd_tgt,
        output btb_entry_upd,
        output btb_entry_updg,
        output btb_entry_clr,
        output btb_entry_clrg
    );

    modport slave (
        output iu_ifu_btb_upd_vld,
        output iu_ifu_btb_upd_del,
        output iu_ifu_btb_upd_tag,
        output iu_ifu_btb_upd_tgt,
        input  ifu_iu_btb_upd_rdy,
        output cp0_ifu_btb_inv,
        input  ifu_cp0_btb_inv_done,
        output btb_entry_wr_hit,
        input  btb_wr_acc_tag,
        input  btb_upd_tag,
        input  btb_upd_tgt,
        input  btb_entry_upd,
        input  btb_entry_updg,
        input  btb_entry_clr,
        input  btb_entry_clrg
    );
endinterface

// File: rtl/pa_ifu_btb_upd_ctrl.sv
// ---------------------------------------------------------------------------
// pa_ifu_btb_upd_ctrl
//
// Purpose:
//   Write-side controller for the BTB entry array. An accepted IU request is
//   buffered, its tag is compared against all entries (LOOKUP), and one cycle
//   later the chosen entry is updated or cleared (WRITE). Installs that miss
//   take a round-robin victim. CP0 whole-BTB invalidation is queued as a
//   pending flag and executed as a single INV cycle that clears every entry,
//   followed by a one-cycle done pulse.
//
// Ports:
//   forever_cpuclk  core clock
//   cpurst          asynchronous active-high reset
//   bus             request / invalidate / array bundle (master modport)
// ---------------------------------------------------------------------------
module pa_ifu_btb_upd_ctrl #(
    parameter int ENTRY_NUM      = 16,
    parameter int PTR_WIDTH      = 4,
    parameter int BTB_ADDR_WIDTH = 16
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    pa_ifu_btb_upd_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2,
        INV    = 2'd3
    } state_e;

    // What the WRITE cycle should do with the selected entry.
    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_UPD  = 2'd1,
        ACT_CLR  = 2'd2
    } act_e;

    state_e                    state_q, state_d;
    logic [PTR_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
    logic                      inv_pend_q, inv_pend_d;
    logic                      done_q, done_d;

    logic                      buf_del_q, buf_del_d;
    logic [BTB_ADDR_WIDTH-1:0] buf_tag_q, buf_tag_d;
    logic [BTB_ADDR_WIDTH-1:0] buf_tgt_q, buf_tgt_d;

    logic [PTR_WIDTH-1:0]      sel_idx_q, sel_idx_d;
    act_e                      sel_act_q, sel_act_d;
    logic                      sel_miss_q, sel_miss_d;

    logic                      upd_rdy;
    logic                      req_accept;
    logic                      hit_any;
    logic [PTR_WIDTH-1:0]      hit_idx;
    logic [ENTRY_NUM-1:0]      sel_onehot;
    logic [ENTRY_NUM-1:0]      entry_upd;
    logic [ENTRY_NUM-1:0]      entry_clr;

    // Requests are refused whenever an invalidate is pending or arriving this
    // very cycle, so invalidation always wins a same-cycle race. Reset also
    // forces rdy low even though the state register already reads IDLE.
    assign upd_rdy    = (state_q == IDLE) & ~inv_pend_q & ~bus.cp0_ifu_btb_inv & ~cpurst;
    assign req_accept = bus.iu_ifu_btb_upd_vld & upd_rdy;

    // Priority encoder picking the lowest-numbered hitting entry; iterating
    // downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        hit_idx = '0;
        hit_any = |bus.btb_entry_wr_hit;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (bus.btb_entry_wr_hit[i]) begin
                hit_idx = i[PTR_WIDTH-1:0];
            end
        end
    end

    // Next-state logic. The request buffer is only loaded on acceptance and
    // the selection registers only in LOOKUP, so the array sees stable data
    // for the whole WRITE cycle. Any invalidate pulse outside INV is folded
    // into the pending flag; a pulse during INV is absorbed by the sequence
    // already running, so it produces no second done pulse.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        inv_pend_d = inv_pend_q | bus.cp0_ifu_btb_inv;
        done_d     = 1'b0;
        buf_del_d  = buf_del_q;
        buf_tag_d  = buf_tag_q;
        buf_tgt_d  = buf_tgt_q;
        sel_idx_d  = sel_idx_q;
        sel_act_d  = sel_act_q;
        sel_miss_d = sel_miss_q;

        case (state_q)
            IDLE: begin
                if (inv_pend_q) begin
                    state_d = INV;
                end else if (req_accept) begin
                    buf_del_d = bus.iu_ifu_btb_upd_del;
                    buf_tag_d = bus.iu_ifu_btb_upd_tag;
                    buf_tgt_d = bus.iu_ifu_btb_upd_tgt;
                    state_d   = LOOKUP;
                end
            end

            LOOKUP: begin
                if (hit_any) begin
                    sel_idx_d  = hit_idx;
                    sel_act_d  = buf_del_q ? ACT_CLR : ACT_UPD;
                    sel_miss_d = 1'b0;
                end else if (!buf_del_q) begin
                    sel_idx_d  = rr_ptr_q;
                    sel_act_d  = ACT_UPD;
                    sel_miss_d = 1'b1;
                end else begin
                    sel_act_d  = ACT_NONE;
                    sel_miss_d = 1'b0;
                end
                state_d = WRITE;
            end

            WRITE: begin
                // Only a freshly allocated victim consumes a round-robin slot;
                // refreshing an existing entry leaves the victim order alone.
                if ((sel_act_q == ACT_UPD) && sel_miss_q) begin
                    rr_ptr_d = rr_ptr_q + 1'b1;
                end
                state_d = inv_pend_q ? INV : IDLE;
            end

            INV: begin
                rr_ptr_d   = '0;
                inv_pend_d = 1'b0;
                done_d     = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset drops any request
    // or invalidate in flight without emitting a strobe or a done pulse.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            inv_pend_q <= 1'b0;
            done_q     <= 1'b0;
            buf_del_q  <= 1'b0;
            buf_tag_q  <= '0;
            buf_tgt_q  <= '0;
            sel_idx_q  <= '0;
            sel_act_q  <= ACT_NONE;
            sel_miss_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            inv_pend_q <= inv_pend_d;
            done_q     <= done_d;
            buf_del_q  <= buf_del_d;
            buf_tag_q  <= buf_tag_d;
            buf_tgt_q  <= buf_tgt_d;
            sel_idx_q  <= sel_idx_d;
            sel_act_q  <= sel_act_d;
            sel_miss_q <= sel_miss_d;
        end
    end

    assign sel_onehot = {{(ENTRY_NUM-1){1'b0}}, 1'b1} << sel_idx_q;

    // Array strobes are decoded purely from registered state, so they fall
    // the instant reset returns the FSM to IDLE. WRITE drives at most one
    // update or one clear bit; INV clears everything. The two never overlap
    // because they come from different states or exclusive actions.
    always_comb begin
        entry_upd = '0;
        entry_clr = '0;
        case (state_q)
            WRITE: begin
                if (sel_act_q == ACT_UPD) begin
                    entry_upd = sel_onehot;
                end else if (sel_act_q == ACT_CLR) begin
                    entry_clr = sel_onehot;
                end
            end
            INV: begin
                entry_clr = '1;
            end
            default: begin
                entry_upd = '0;
                entry_clr = '0;
            end
        endcase
    end

    assign bus.ifu_iu_btb_upd_rdy   = upd_rdy;
    assign bus.ifu_cp0_btb_inv_done = done_q;
    assign bus.btb_wr_acc_tag       = buf_tag_q;
    assign bus.btb_upd_tag          = buf_tag_q;
    assign bus.btb_upd_tgt          = buf_tgt_q;
    assign bus.btb_entry_upd        = entry_upd;
    assign bus.btb_entry_updg       = entry_upd;
    assign bus.btb_entry_clr        = entry_clr;
    assign bus.btb_entry_clrg       = entry_clr;

endmodule

// File: tb/tb_pa_ifu_btb_upd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pa_ifu_btb_upd_ctrl
//
// Testbench for the BTB update controller. Requests are issued by a driver
// that also feeds a small reference model; the model pushes the expected
// array write events into a queue, and an independent monitor pops and
// compares whenever the controller raises a strobe or a done pulse.
// ---------------------------------------------------------------------------
module tb_pa_ifu_btb_upd_ctrl;

    localparam int EN = 16;
    localparam int AW = 16;

    localparam int KIND_UPD  = 0;
    localparam int KIND_CLR  = 1;
    localparam int KIND_DONE = 2;

    typedef struct {
        int            kind;
        logic [EN-1:0] mask;
        logic [AW-1:0] tag;
        logic [AW-1:0] tgt;
        int            cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;

    ev_t expQ[$];
    int  checks  = 0;
    int  errors  = 0;
    int  cycle   = 0;
    int  rrModel = 0;

    pa_ifu_btb_upd_ctrl_if #(.ENTRY_NUM(EN), .BTB_ADDR_WIDTH(AW)) ifc ();

    pa_ifu_btb_upd_ctrl #(
        .ENTRY_NUM      (EN),
        .PTR_WIDTH      (4),
        .BTB_ADDR_WIDTH (AW)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (ifc.master)
    );

    // Free-running clock and cycle counter; the counter value seen at a
    // falling edge names the cycle that edge sits in.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Generic compare used by both the driver and the monitor.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model for one accepted request: the lowest hitting entry is
    // refreshed or cleared; a miss installs at the round-robin slot; a
    // delete that misses does nothing at all. Writes land two cycles later.
    function automatic void modelRequest(input logic del, input logic [AW-1:0] tag,
                                         input logic [AW-1:0] tgt, input logic [EN-1:0] hit,
                                         input int acceptCycle);
        ev_t e;
        int  idx;
        e.tag  = tag;
        e.tgt  = tgt;
        e.cyc  = acceptCycle + 2;
        e.mask = '0;
        idx    = -1;
        for (int i = 0; i < EN; i++) begin
            if (hit[i] && idx < 0) idx = i;
        end
        if (idx >= 0) begin
            e.kind      = del ? KIND_CLR : KIND_UPD;
            e.mask[idx] = 1'b1;
            expQ.push_back(e);
        end else if (!del) begin
            e.kind          = KIND_UPD;
            e.mask[rrModel] = 1'b1;
            rrModel         = (rrModel + 1) % EN;
            expQ.push_back(e);
        end
    endfunction

    // Reference model for an invalidate that executes in invCycle.
    function automatic void modelInv(input int invCycle);
        ev_t e;
        e.kind = KIND_CLR;
        e.mask = '1;
        e.tag  = '0;
        e.tgt  = '0;
        e.cyc  = invCycle;
        expQ.push_back(e);
        e.kind = KIND_DONE;
        e.mask = '0;
        e.cyc  = invCycle + 1;
        expQ.push_back(e);
        rrModel = 0;
    endfunction

    // Waits (bounded) for rdy, presents one request with its hit vector, and
    // returns just after the accepting edge. The hit vector is held until the
    // next request, covering the LOOKUP cycle; tag/tgt are scrambled after
    // acceptance so late sampling would be visible.
    task automatic applyStimulus(input logic del, input logic [AW-1:0] tag,
                                 input logic [AW-1:0] tgt, input logic [EN-1:0] hit);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!ifc.ifu_iu_btb_upd_rdy && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!ifc.ifu_iu_btb_upd_rdy) begin
            checkOutput("rdyTimeout", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd1);
            return;
        end
        ifc.iu_ifu_btb_upd_vld = 1'b1;
        ifc.iu_ifu_btb_upd_del = del;
        ifc.iu_ifu_btb_upd_tag = tag;
        ifc.iu_ifu_btb_upd_tgt = tgt;
        ifc.btb_entry_wr_hit   = hit;
        modelRequest(del, tag, tgt, hit, cycle);
        @(posedge clk);
        #1;
        ifc.iu_ifu_btb_upd_vld = 1'b0;
        ifc.iu_ifu_btb_upd_del = ~del;
        ifc.iu_ifu_btb_upd_tag = ~tag;
        ifc.iu_ifu_btb_upd_tgt = ~tgt;
    endtask

    // Monitor: every falling edge outside reset, any strobe or done pulse is
    // matched against the head of the expected-event queue.
    initial begin
        ev_t           e;
        logic [EN-1:0] upd, clr;
        forever begin
            @(negedge clk);
            if (!rst) begin
                upd = ifc.btb_entry_upd;
                clr = ifc.btb_entry_clr;
                if ((upd | clr) != '0) begin
                    checkOutput("updgEqUpd", 64'(ifc.btb_entry_updg), 64'(upd));
                    checkOutput("clrgEqClr", 64'(ifc.btb_entry_clrg), 64'(clr));
                    checkOutput("updClrOverlap", 64'(upd & clr), 64'd0);
                    checkOutput("updOneHot", 64'($countones(upd) > 1), 64'd0);
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedStrobe", 64'(upd | clr), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("eventKind", 64'((upd != '0) ? KIND_UPD : KIND_CLR), 64'(e.kind));
                        checkOutput("eventCycle", 64'(cycle), 64'(e.cyc));
                        if (e.kind == KIND_UPD) begin
                            checkOutput("updMask", 64'(upd), 64'(e.mask));
                            checkOutput("updTag", 64'(ifc.btb_upd_tag), 64'(e.tag));
                            checkOutput("updTgt", 64'(ifc.btb_upd_tgt), 64'(e.tgt));
                            checkOutput("accTag", 64'(ifc.btb_wr_acc_tag), 64'(e.tag));
                        end else begin
                            checkOutput("clrMask", 64'(clr), 64'(e.mask));
                            if (e.mask != '1) begin
                                checkOutput("accTag", 64'(ifc.btb_wr_acc_tag), 64'(e.tag));
                            end
                        end
                    end
                end
                if (ifc.ifu_cp0_btb_inv_done) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedDone", 64'(ifc.ifu_cp0_btb_inv_done), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("doneKind", 64'(KIND_DONE), 64'(e.kind));
                        checkOutput("doneCycle", 64'(cycle), 64'(e.cyc));
                    end
                end
            end
        end
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int            waitCnt;
        logic [EN-1:0] hit;

        rst = 1'b1;
        ifc.iu_ifu_btb_upd_vld = 1'b0;
        ifc.iu_ifu_btb_upd_del = 1'b0;
        ifc.iu_ifu_btb_upd_tag = '0;
        ifc.iu_ifu_btb_upd_tgt = '0;
        ifc.cp0_ifu_btb_inv    = 1'b0;
        ifc.btb_entry_wr_hit   = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("resetRdy", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd0);
        checkOutput("resetUpd", 64'(ifc.btb_entry_upd), 64'd0);
        checkOutput("resetClr", 64'(ifc.btb_entry_clr), 64'd0);
        checkOutput("resetDone", 64'(ifc.ifu_cp0_btb_inv_done), 64'd0);
        checkOutput("resetAccTag", 64'(ifc.btb_wr_acc_tag), 64'd0);
        checkOutput("resetUpdTgt", 64'(ifc.btb_upd_tgt), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rdyAfterReset", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd1);

        // First install miss lands in entry 0; rdy is low for LOOKUP and WRITE.
        applyStimulus(1'b0, 16'h1234, 16'h5678, 16'h0000);
        @(negedge clk);
        checkOutput("rdyLookup", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd0);
        @(negedge clk);
        checkOutput("rdyWrite", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd0);
        @(negedge clk);
        checkOutput("rdyBack", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd1);

        // Refresh hit, multi-hit delete, delete miss.
        applyStimulus(1'b0, 16'hAAAA, 16'hBBBB, 16'h0020);
        applyStimulus(1'b1, 16'hCCCC, 16'h0000, 16'h0110);
        applyStimulus(1'b1, 16'hDDDD, 16'h0000, 16'h0000);

        // Invalidate arriving during the LOOKUP of an install.
        applyStimulus(1'b0, 16'h0F0F, 16'hF0F0, 16'h0000);
        @(negedge clk);
        ifc.cp0_ifu_btb_inv = 1'b1;
        modelInv(cycle + 2);
        @(negedge clk);
        ifc.cp0_ifu_btb_inv = 1'b0;

        // Seventeen install misses walk all entries and wrap to entry 0.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, AW'(16'h4000 + i), AW'(16'h8000 + i), 16'h0000);
        end

        // Invalidate from IDLE blocks rdy that cycle; repeat pulses merge.
        waitCnt = 0;
        @(negedge clk);
        while (!ifc.ifu_iu_btb_upd_rdy && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        ifc.cp0_ifu_btb_inv = 1'b1;
        #1;
        checkOutput("rdyBlockedByInv", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd0);
        modelInv(cycle + 2);
        repeat (2) @(negedge clk);
        ifc.cp0_ifu_btb_inv = 1'b1;
        @(negedge clk);
        ifc.cp0_ifu_btb_inv = 1'b0;

        // Reset in the middle of a WRITE cycle.
        applyStimulus(1'b0, 16'h7777, 16'h8888, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetUpd", 64'(ifc.btb_entry_upd), 64'd0);
        checkOutput("midResetClr", 64'(ifc.btb_entry_clr), 64'd0);
        rrModel = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rdyAfterMidReset", 64'(ifc.ifu_iu_btb_upd_rdy), 64'd1);
        applyStimulus(1'b0, 16'h1111, 16'h2222, 16'h0000);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    hit = '0;
                2:       hit = EN'(1) << $urandom_range(0, EN - 1);
                default: hit = EN'($urandom());
            endcase
            applyStimulus(($urandom_range(0, 9) < 3), AW'($urandom()), AW'($urandom()), hit);
        end

        // Let every expected event retire.
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
